main_memory_ctrl: RTL
=====================

MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4, access latency in cycles (legal 1..15).
REQ-002 SHALL have parameter NBLOCKS, default 64, number of 128-bit blocks (1 KB).
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req  input  1  access request from cache, sampled only in IDLE.
REQ-006 SHALL have port we  input  1  1 = block write (write-through), 0 = block read (miss fill).
REQ-007 SHALL have port addr  input  10  byte address from cache; addr[9:4] = block index, addr[3:0] ignored.
REQ-008 SHALL have port wdata  input  128  full block to store on write.
REQ-009 SHALL have port rdata  output  128  block returned by last completed read.
REQ-010 SHALL have port busy  output  1  high while a request is accepted and not yet done.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE: on req=1 at a rising edge, SHALL capture addr[9:4], we, wdata, load counter with LATENCY-1, go to BUSY; req=0 stays IDLE.
REQ-014 BUSY: counter decrements each cycle; at counter=0 SHALL perform the access and go to DONE.
REQ-015 Read access SHALL load rdata with array[index] (word j of block in bits [32j+31:32j]); write access SHALL store captured wdata into array[index], rdata unchanged.
REQ-016 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-017 busy SHALL be 1 in BUSY and DONE, 0 in IDLE.
REQ-018 Latency: req sampled at edge k -> done high during the cycle after edge k+LATENCY; rdata valid in that same cycle.
REQ-019 req, we, addr, wdata SHALL be ignored outside IDLE; changes mid-access SHALL not affect the operation in flight.
REQ-020 req held high through DONE SHALL be accepted at the first IDLE edge; back-to-back throughput = LATENCY+2 cycles per access.
REQ-021 rdata SHALL hold its value until the next read completes.
REQ-022 Write followed by read of same block SHALL return the written data (no stale read).
REQ-023 Array initial contents (simulation load): 32-bit word j (byte addr 4j, j=0..255) = j.

Reset
REQ-024 reset_n=0 at an edge SHALL force IDLE, counter=0, rdata=0, busy=0, done=0.
REQ-025 Reset mid-access SHALL abort: no write committed, no done pulse.
REQ-026 Array contents SHALL NOT be cleared by reset.
REQ-027 Reset SHALL take priority over req in the same edge.

Structure
REQ-028 Shared package mem_pkg SHALL hold ADDR_W=10, BLOCK_W=128, IDX_W=6, WORD_W=32 and the FSM state type.
REQ-029 Storage SHALL be sub-module mem_array (NBLOCKS x 128, synchronous write, synchronous read, one port); controller holds FSM, counter, capture registers.
REQ-030 Counter width SHALL be 4 bits; no combinational path from inputs to outputs.

Verification
REQ-031 Read: reset, req=1 we=0 addr=10'h010 -> done 5 cycles after accept edge, rdata=128'h00000007_00000006_00000005_00000004.
REQ-032 Write then read: write addr=10'h3F0 wdata=128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, then read addr=10'h3FC -> rdata equals that block; rdata unchanged after the write's done.
REQ-033 Input churn: during BUSY of a read of addr=10'h000 drive addr=10'h020, we=1 -> rdata=128'h00000003_00000002_00000001_00000000, block 2 unmodified.
REQ-034 Reset mid-write: reset_n=0 for 1 cycle in BUSY of write to addr=10'h040 -> no done, subsequent read of 10'h040 returns original words 16..19.
REQ-035 Back-to-back: req held high for 3 reads -> done pulses exactly 6 cycles apart, busy low exactly one cycle between accesses.
REQ-036 LATENCY=1 instance: read addr=10'h000 -> done in cycle after accept edge+1, single-cycle pulse.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg : shared widths, FSM state type and array init helper         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mem_pkg;

   localparam int ADDR_W  = 10;
   localparam int BLOCK_W = 128;
   localparam int IDX_W   = 6;
   localparam int WORD_W  = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Power-up image: 32-bit word j of the whole memory holds the value j.
   function automatic logic [BLOCK_W-1:0] init_block(input int unsigned idx);
      logic [BLOCK_W-1:0] blk;
      blk = '0;
      for (int j = 0; j < BLOCK_W / WORD_W; j++) begin
         blk[j*WORD_W +: WORD_W] = WORD_W'(idx * (BLOCK_W / WORD_W) + unsigned'(j));
      end
      return blk;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_array : single-port block store, synchronous write and read       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mem_array
   import mem_pkg::*;
#(
   parameter int unsigned NBLOCKS = 64
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               i_en,
   input  logic               i_we,
   input  logic [IDX_W-1:0]   i_idx,
   input  logic [BLOCK_W-1:0] i_wdata,
   output logic [BLOCK_W-1:0] o_rdata
);

   logic [BLOCK_W-1:0] w_blk [NBLOCKS];
   logic [BLOCK_W-1:0] r_rdata;

   // Storage is deliberately outside the reset domain; only the read register clears.
   generate
      for (genvar b = 0; b < NBLOCKS; b++) begin : g_blk
         logic [BLOCK_W-1:0] r_data = init_block(b);

         always_ff @(posedge clock) begin
            if (i_en && i_we && (i_idx == IDX_W'(b))) begin
               r_data <= i_wdata;
            end
         end

         assign w_blk[b] = r_data;
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_rdata <= '0;
      end else if (i_en && !i_we) begin
         r_rdata <= w_blk[i_idx];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/main_memory_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | main_memory_ctrl : fixed-latency block memory behind the cache        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module main_memory_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned NBLOCKS = 64
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               req,
   input  logic               we,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [BLOCK_W-1:0] wdata,
   output logic [BLOCK_W-1:0] rdata,
   output logic               busy,
   output logic               done
);

   localparam logic [3:0] c_cnt_load = 4'(LATENCY - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [3:0]         r_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic               r_we;
   logic [BLOCK_W-1:0] r_wdata;
   logic               w_access;
   logic               w_unused_addr;

   assign w_unused_addr = ^addr[ADDR_W-IDX_W-1:0];

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (req) begin
                  r_idx   <= addr[ADDR_W-1 -: IDX_W];
                  r_we    <= we;
                  r_wdata <= wdata;
                  r_cnt   <= c_cnt_load;
               end
            end
            BUSY: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (req) w_state_nxt = BUSY;
         BUSY:    if (r_cnt == 4'd0) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Gating with reset_n keeps an aborted write from landing on the reset edge.
   assign w_access = reset_n && (r_state == BUSY) && (r_cnt == 4'd0);

   mem_array #(
      .NBLOCKS (NBLOCKS)
   ) u_mem_array (
      .clock   (clock),
      .reset_n (reset_n),
      .i_en    (w_access),
      .i_we    (r_we),
      .i_idx   (r_idx),
      .i_wdata (r_wdata),
      .o_rdata (rdata)
   );

   assign busy = (r_state != IDLE);
   assign done = (r_state == DONE);

endmodule
`default_nettype wire
